ofifo_drain_ctrl: RTL and testbench
===================================

OFIFO_DRAIN_CTRL -- requirements
Module: ofifo_drain_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, number of PE columns / OFIFO lanes.
REQ-002 SHALL have parameter psum_bw, default 16, bits per partial sum.
REQ-003 SHALL have parameter addr_bw, default 11, psum SRAM address width.
REQ-004 SHALL have parameter rd_lat, default 2, cycles from ofifo_rd high to row valid on ofifo_out.
REQ-005 SHALL have ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a drain job.
- base_addr  input  addr_bw  first SRAM address; sampled on accepted start.
- num_rows  input  addr_bw  rows to drain; sampled on accepted start.
- ofifo_valid  input  1  OFIFO all lanes non-empty.
- ofifo_out  input  psum_bw*col  OFIFO read data.
- ofifo_rd  output  1  OFIFO read request.
- sram_wen  output  1  SRAM write enable, active-high.
- sram_addr  output  addr_bw  SRAM write address.
- sram_din  output  psum_bw*col  SRAM write data.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at job completion.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, WRITE.
REQ-007 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-008 Accepted start with num_rows = 0 SHALL stay in IDLE and pulse done the next cycle, with no ofifo_rd or sram_wen.
REQ-009 Accepted start with num_rows > 0 SHALL latch base_addr into the address counter and num_rows into the remaining counter, then enter ISSUE.
REQ-010 In ISSUE, ofifo_rd SHALL be high for exactly one cycle, and only when ofifo_valid = 1; otherwise the FSM SHALL hold in ISSUE with ofifo_rd = 0.
REQ-011 After the ofifo_rd cycle, the FSM SHALL wait in WAIT until rd_lat cycles have elapsed since ofifo_rd, then enter WRITE.
REQ-012 WRITE SHALL last one cycle, with sram_wen = 1, sram_addr = address counter, and sram_din = ofifo_out sampled that cycle.
REQ-013 At most one OFIFO read SHALL be outstanding; the maximum rate is one row per rd_lat+2 cycles.
REQ-014 After WRITE, the address counter SHALL increment modulo 2^addr_bw (wrap from all-ones to 0) and the remaining counter SHALL decrement.
REQ-015 After WRITE, if remaining becomes 0, the FSM SHALL go to IDLE and assert done in that same transition cycle; otherwise it SHALL return to ISSUE.
REQ-016 busy SHALL be 1 in ISSUE, WAIT and WRITE, and 0 in IDLE.
REQ-017 ofifo_rd, sram_wen and done SHALL be registered outputs, never combinational from inputs.
REQ-018 sram_din SHALL be 0 whenever sram_wen = 0.

Reset
REQ-019 Assertion of reset SHALL immediately force state IDLE and ofifo_rd, sram_wen, busy and done to 0.
REQ-020 Assertion of reset SHALL immediately force sram_addr, sram_din and all counters to 0.
REQ-021 Reset mid-job SHALL abandon the job with no done pulse, and the next accepted start SHALL run normally.

Structure
REQ-022 The state encoding and rd_lat default SHALL reside in the shared accelerator package; col and psum_bw SHALL come from the package constants used by the OFIFO.
REQ-023 A single sub-module, drain_lat_cnt (a loadable down-counter for the WAIT phase), SHALL be used; everything else SHALL be flat.

Verification
REQ-024 The bench SHALL drive base_addr=5, num_rows=3, with ofifo_valid held at 1 and rows 0xA, 0xB, 0xC, and check three writes at addresses 5, 6, 7 with that data, 4 cycles apart, and done one cycle after the last WRITE.
REQ-025 The bench SHALL hold ofifo_valid low for 10 cycles after start and check ofifo_rd = 0 and state ISSUE throughout, then check normal completion once ofifo_valid rises.
REQ-026 The bench SHALL start with base_addr=0x7FF and num_rows=2 and check writes at 0x7FF then 0x000.
REQ-027 The bench SHALL start with num_rows=0 and check done the next cycle and that ofifo_rd and sram_wen never assert.
REQ-028 The bench SHALL assert reset during WAIT of row 2 of 4 and check all outputs are 0 asynchronously with no done pulse, then check a fresh num_rows=1 job completes.
REQ-029 The bench SHALL pulse start again while busy and check it has no effect on counters or addresses.

Source files
------------

// File: rtl/ofifo_drain_ctrl_pkg.sv
// rtl/ofifo_drain_ctrl_pkg.sv - shared accelerator constants and drain FSM encoding
//
// Holds the OFIFO geometry (lane count, partial-sum width), the default OFIFO
// read latency and the drain controller state encoding.
package ofifo_drain_ctrl_pkg;

    // OFIFO geometry shared with the array/OFIFO
    localparam int ofifo_col     = 8;
    localparam int ofifo_psum_bw = 16;

    // Cycles from ofifo_rd high to the row being valid on ofifo_out
    localparam int drain_rd_lat  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } drain_state_t;

    // Bits needed by the WAIT down-counter; it never holds more than lat-1.
    function automatic int lat_cnt_width(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/ofifo_drain_ctrl_if.sv
// rtl/ofifo_drain_ctrl_if.sv - OFIFO read and psum SRAM write bundle
//
// Signals:
//   ofifo_valid  OFIFO all lanes non-empty
//   ofifo_out    OFIFO read data (psum_bw*col)
//   ofifo_rd     OFIFO read request
//   sram_wen     SRAM write enable, active-high
//   sram_addr    SRAM write address
//   sram_din     SRAM write data
// master: the drain controller; slave: the OFIFO/SRAM side.
interface ofifo_drain_ctrl_if
    import ofifo_drain_ctrl_pkg::*;
#(
    parameter int col     = ofifo_col,
    parameter int psum_bw = ofifo_psum_bw,
    parameter int addr_bw = 11
);
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     sram_wen;
    logic [addr_bw-1:0]       sram_addr;
    logic [psum_bw*col-1:0]   sram_din;

    modport master (
        input  ofifo_valid,
        input  ofifo_out,
        output ofifo_rd,
        output sram_wen,
        output sram_addr,
        output sram_din
    );

    modport slave (
        output ofifo_valid,
        output ofifo_out,
        input  ofifo_rd,
        input  sram_wen,
        input  sram_addr,
        input  sram_din
    );
endinterface

// File: rtl/ofifo_drain_ctrl_drain_lat_cnt.sv
// rtl/ofifo_drain_ctrl_drain_lat_cnt.sv - loadable down-counter timing the WAIT phase
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   load        load load_val this cycle
//   load_val    starting count
//   expired     count is zero
module drain_lat_cnt #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_val,
    output logic             expired
);
    logic [width-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/ofifo_drain_ctrl.sv
// rtl/ofifo_drain_ctrl.sv - drains OFIFO rows into consecutive psum SRAM addresses
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle pulse, accepted only in IDLE
//   base_addr  first SRAM address, sampled on accepted start
//   num_rows   rows to drain, sampled on accepted start
//   bus        OFIFO read / SRAM write bundle (master side)
//   busy       job in progress
//   done       one-cycle pulse at job completion
//
// Per row: ISSUE waits for ofifo_valid, then raises ofifo_rd for one cycle;
// WAIT covers the rest of the read latency; WRITE stores the row. One read is
// outstanding at a time, giving one row every rd_lat+2 cycles.
module ofifo_drain_ctrl
    import ofifo_drain_ctrl_pkg::*;
#(
    parameter int col     = ofifo_col,
    parameter int psum_bw = ofifo_psum_bw,
    parameter int addr_bw = 11,
    parameter int rd_lat  = drain_rd_lat
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_bw-1:0]        base_addr,
    input  logic [addr_bw-1:0]        num_rows,
    ofifo_drain_ctrl_if.master        bus,
    output logic                      busy,
    output logic                      done
);
    localparam int  data_w    = psum_bw * col;
    localparam int  lat_w     = lat_cnt_width(rd_lat);
    // With a one-cycle read latency the row is ready right after the read,
    // so the WAIT phase collapses to nothing.
    localparam bit  skip_wait = (rd_lat <= 1);
    // The ofifo_rd cycle already counts as one latency cycle.
    localparam logic [lat_w-1:0] wait_load = lat_w'(rd_lat - 2);

    drain_state_t       state, state_nx;
    logic               rd_q, rd_nx;
    logic               wen_q, wen_nx;
    logic               done_q, done_nx;
    logic [addr_bw-1:0] addr_q, addr_nx;
    logic [addr_bw-1:0] rem_q, rem_nx;
    logic               lat_load;
    logic               lat_expired;

    drain_lat_cnt #(.width(lat_w)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (wait_load),
        .expired  (lat_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rd_q   <= 1'b0;
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_nx;
            rd_q   <= rd_nx;
            wen_q  <= wen_nx;
            done_q <= done_nx;
            addr_q <= addr_nx;
            rem_q  <= rem_nx;
        end
    end

    // Next state plus next values of the registered outputs, so ofifo_rd,
    // sram_wen and done are all flop outputs.
    always_comb begin
        state_nx = state;
        rd_nx    = 1'b0;
        wen_nx   = 1'b0;
        done_nx  = 1'b0;
        addr_nx  = addr_q;
        rem_nx   = rem_q;
        lat_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        addr_nx  = base_addr;
                        rem_nx   = num_rows;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // rd_q high means this is the single read cycle of the row.
                if (rd_q) begin
                    if (skip_wait) begin
                        state_nx = WRITE;
                        wen_nx   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        lat_load = 1'b1;
                    end
                end else if (bus.ofifo_valid) begin
                    rd_nx = 1'b1;
                end
            end
            WAIT: begin
                if (lat_expired) begin
                    state_nx = WRITE;
                    wen_nx   = 1'b1;
                end
            end
            WRITE: begin
                addr_nx = addr_q + 1'b1;
                rem_nx  = rem_q - 1'b1;
                if (rem_q == {{(addr_bw-1){1'b0}}, 1'b1}) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ISSUE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ofifo_rd  = rd_q;
    assign bus.sram_wen  = wen_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = wen_q ? bus.ofifo_out : {data_w{1'b0}};
    assign busy          = (state != IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb/tb_ofifo_drain_ctrl.sv - directed self-checking bench for ofifo_drain_ctrl
module tb_ofifo_drain_ctrl;
    import ofifo_drain_ctrl_pkg::*;

    localparam int aw = 11;
    localparam int dw = ofifo_col * ofifo_psum_bw;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [aw-1:0] base_addr = '0;
    logic [aw-1:0] num_rows = '0;
    logic          busy;
    logic          done;

    ofifo_drain_ctrl_if #(.col(ofifo_col), .psum_bw(ofifo_psum_bw), .addr_bw(aw)) ifc ();

    ofifo_drain_ctrl #(.col(ofifo_col), .psum_bw(ofifo_psum_bw), .addr_bw(aw), .rd_lat(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .bus       (ifc.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // OFIFO model: a read in cycle c presents rows[idx] on ofifo_out in cycle c+2 only.
    logic [dw-1:0] rows [64];
    int            rd_idx;
    logic [dw-1:0] p1;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1            <= '0;
            ifc.ofifo_out <= '0;
            rd_idx        <= 0;
        end else begin
            p1            <= ifc.ofifo_rd ? rows[rd_idx] : '0;
            ifc.ofifo_out <= p1;
            if (ifc.ofifo_rd) rd_idx <= rd_idx + 1;
        end
    end

    // Monitor: only appends, the stimulus snapshots sizes before each job.
    int            wr_cyc [$];
    logic [aw-1:0] wr_addr [$];
    logic [dw-1:0] wr_data [$];
    int            done_cyc [$];
    int            rd_cnt = 0;
    int            din_bad = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.sram_wen) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(ifc.sram_addr);
                wr_data.push_back(ifc.sram_din);
            end else if (ifc.sram_din != '0) begin
                din_bad++;
            end
            if (done) done_cyc.push_back(cyc);
            if (ifc.ofifo_rd) rd_cnt++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [dw-1:0] got, input logic [dw-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [aw-1:0] b, input logic [aw-1:0] n, output int k);
        @(negedge clk);
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        k         = cyc + 1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic finish_job(input string tag, input logic [aw-1:0] b, input int n,
                              input int w0, input int d0, input int r0, input bit timing);
        bit            ok;
        logic [aw-1:0] ea;
        int            nw;
        wait_done(200, ok);
        check({tag, " done_seen"}, dw'(ok), dw'(1));
        nw = wr_cyc.size() - w0;
        check({tag, " n_writes"}, dw'(nw), dw'(n));
        check({tag, " n_done"}, dw'(done_cyc.size() - d0), dw'(1));
        for (int i = 0; i < n && i < nw; i++) begin
            ea = b + aw'(i);
            check({tag, " addr"}, dw'(wr_addr[w0+i]), dw'(ea));
            check({tag, " data"}, wr_data[w0+i], rows[r0+i]);
            if (timing && i > 0)
                check({tag, " spacing"}, dw'(wr_cyc[w0+i] - wr_cyc[w0+i-1]), dw'(4));
        end
        if (nw > 0 && done_cyc.size() > d0)
            check({tag, " done_after_write"}, dw'(done_cyc[d0]), dw'(wr_cyc[wr_cyc.size()-1] + 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ofifo_rd"}, dw'(ifc.ofifo_rd), dw'(0));
        check({tag, " sram_wen"}, dw'(ifc.sram_wen), dw'(0));
        check({tag, " sram_addr"}, dw'(ifc.sram_addr), dw'(0));
        check({tag, " sram_din"}, ifc.sram_din, dw'(0));
        check({tag, " busy"}, dw'(busy), dw'(0));
        check({tag, " done"}, dw'(done), dw'(0));
        check({tag, " state"}, dw'(dut.state), dw'(IDLE));
    endtask

    initial begin
        int  k, w0, d0, r0, rc0;
        bit  hit;
        ifc.ofifo_valid = 1'b1;
        for (int i = 0; i < 64; i++) rows[i] = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic three-row job with fixed data
        rows[rd_idx]   = dw'(128'hA);
        rows[rd_idx+1] = dw'(128'hB);
        rows[rd_idx+2] = dw'(128'hC);
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = rd_idx;
        launch(11'd5, 11'd3, k);
        finish_job("basic", 11'd5, 3, w0, d0, r0, 1'b1);

        // OFIFO empty for 10 cycles after start
        ifc.ofifo_valid = 1'b0;
        rows[rd_idx]   = {4{32'h1111_2222}};
        rows[rd_idx+1] = {4{32'h3333_4444}};
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = rd_idx; rc0 = rd_cnt;
        launch(11'h040, 11'd2, k);
        for (int i = 0; i < 10; i++) begin
            check("stall ofifo_rd", dw'(ifc.ofifo_rd), dw'(0));
            check("stall state", dw'(dut.state), dw'(ISSUE));
            @(negedge clk);
        end
        check("stall no_reads", dw'(rd_cnt - rc0), dw'(0));
        ifc.ofifo_valid = 1'b1;
        finish_job("stall", 11'h040, 2, w0, d0, r0, 1'b1);

        // Address wrap from all-ones to zero
        rows[rd_idx]   = dw'(128'h0123_4567_89AB_CDEF);
        rows[rd_idx+1] = dw'(128'hFEDC_BA98_7654_3210_0000_0000_0000_0001);
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = rd_idx;
        launch(11'h7FF, 11'd2, k);
        finish_job("wrap", 11'h7FF, 2, w0, d0, r0, 1'b1);

        // Zero-row job: done next cycle, no traffic
        w0 = wr_cyc.size(); d0 = done_cyc.size(); rc0 = rd_cnt;
        launch(11'h123, 11'd0, k);
        repeat (6) @(negedge clk);
        #1;
        check("zero n_done", dw'(done_cyc.size() - d0), dw'(1));
        if (done_cyc.size() > d0) check("zero done_cycle", dw'(done_cyc[d0]), dw'(k));
        check("zero n_writes", dw'(wr_cyc.size() - w0), dw'(0));
        check("zero n_reads", dw'(rd_cnt - rc0), dw'(0));

        // Reset during WAIT of row 2 of 4
        for (int i = 0; i < 4; i++) rows[rd_idx+i] = dw'(100 + i);
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        launch(11'h030, 11'd4, k);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dut.state == WAIT && (wr_cyc.size() - w0) == 1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort reached_wait", dw'(hit), dw'(1));
        #2 reset = 1'b1;
        #1 check_all_zero("abort async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("abort no_done", dw'(done_cyc.size() - d0), dw'(0));
        check("abort n_writes", dw'(wr_cyc.size() - w0), dw'(1));

        rows[rd_idx] = dw'(128'h5A5A);
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = rd_idx;
        launch(11'h3FE, 11'd1, k);
        finish_job("after_abort", 11'h3FE, 1, w0, d0, r0, 1'b0);

        // Start pulsed while busy must be ignored
        for (int i = 0; i < 3; i++) rows[rd_idx+i] = dw'(200 + i);
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = rd_idx;
        launch(11'h010, 11'd3, k);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((wr_cyc.size() - w0) >= 1) begin
                hit = 1'b1;
                break;
            end
        end
        check("busy_start first_write", dw'(hit), dw'(1));
        base_addr = 11'h100;
        num_rows  = 11'd7;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        check("busy_start addr_cnt", dw'(ifc.sram_addr), dw'(11'h011));
        finish_job("busy_start", 11'h010, 3, w0, d0, r0, 1'b1);

        check("din_zero_when_idle", dw'(din_bad), dw'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
